// File: rtl/sae_pkg.sv
// sae_pkg: types and helpers shared by the streaming SAE engine.
//   sae_mode_t      - transaction opcode carried on in_mode/out_mode
//   SAE_DEFAULT_MOD - default modulus of the engine
//   sae_key_ok()    - key range check, 1 <= key <= mod-1
package sae_pkg;

  typedef enum logic [1:0] {
    SAE_NOP    = 2'b00,
    SAE_KEYGEN = 2'b01,
    SAE_ENC    = 2'b10,
    SAE_DEC    = 2'b11
  } sae_mode_t;

  localparam int unsigned SAE_DEFAULT_MOD = 223;

  function automatic logic sae_key_ok(input int unsigned key, input int unsigned mod);
    return (key >= 32'd1) && (key <= mod - 32'd1);
  endfunction

endpackage

// File: rtl/sae_fifo.sv
// sae_fifo: synchronous in-order FIFO with a registered occupancy count.
//   clk, reset       - clock, asynchronous active-high reset
//   push_i, wdata_i  - write request and data (ignored when full without a pop)
//   pop_i            - remove the head (ignored when empty)
//   rdata_o          - head entry, meaningful only while count_o != 0
//   count_o          - number of stored entries
module sae_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides what is valid, and the
  // head is masked by the consumer while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sae_stream.sv
// sae_stream: streaming SAE engine (KEYGEN / ENC / DEC modulo MOD).
//   clk, reset                        - clock, asynchronous active-high reset
//   in_valid/in_ready                 - input handshake; in_mode, in_data, in_key
//   out_valid/out_ready               - output handshake; out_data, out_mode, out_err
//   err_cnt                           - saturating count of bad-key transactions
// Stage 1 registers the unreduced sum, stage 2 reduces it into the FIFO.
module sae_stream
  import sae_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MOD    = SAE_DEFAULT_MOD,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_mode,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  if (!((MOD > (2 ** (DATA_W - 1))) && (MOD < (2 ** DATA_W)))) begin : g_bad_mod
    $error("sae_stream: MOD must satisfy 2**(DATA_W-1) < MOD < 2**DATA_W");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sae_stream: DEPTH must be at least 2");
  end

  // The MOD bound keeps every sum below 3*MOD, and 2*MOD fits DATA_W+1 bits.
  localparam logic [DATA_W:0] MOD_S  = (DATA_W + 1)'(MOD);
  localparam logic [DATA_W:0] MOD2_S = (DATA_W + 1)'(2 * MOD);

  typedef struct packed {
    sae_mode_t         mode;
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  sae_mode_t         mode_in;
  logic              accept, s1_load;
  logic              s1_valid_q, s1_err_q, s1_err_d;
  sae_mode_t         s1_mode_q;
  logic [DATA_W:0]   s1_sum_q, s1_sum_d;
  logic [DATA_W-1:0] reduced;
  entry_t            wr_entry, head;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic [CNT_W-1:0]  err_cnt_q;

  assign mode_in = sae_mode_t'(in_mode);
  assign accept  = in_valid && in_ready;
  assign s1_load = accept && (mode_in != SAE_NOP);

  // Errored keys load a zero sum, which reduces to the required zero result.
  always_comb begin
    s1_sum_d = '0;
    s1_err_d = !sae_key_ok(32'(in_key), MOD);
    if (!s1_err_d) begin
      unique case (mode_in)
        SAE_KEYGEN:       s1_sum_d = MOD_S - {1'b0, in_key};
        SAE_ENC, SAE_DEC: s1_sum_d = {1'b0, in_data} + {1'b0, in_key};
        default:          s1_sum_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= SAE_NOP;
      s1_err_q   <= 1'b0;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= s1_load;
      if (s1_load) begin
        s1_mode_q <= mode_in;
        s1_err_q  <= s1_err_d;
        s1_sum_q  <= s1_sum_d;
      end
    end
  end

  always_comb begin
    if (s1_sum_q >= MOD2_S)     reduced = DATA_W'(s1_sum_q - MOD2_S);
    else if (s1_sum_q >= MOD_S) reduced = DATA_W'(s1_sum_q - MOD_S);
    else                        reduced = DATA_W'(s1_sum_q);
  end

  assign wr_entry = '{mode: s1_mode_q, err: s1_err_q, data: reduced};

  sae_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (s1_valid_q),
    .wdata_i (wr_entry),
    .pop_i   (out_valid && out_ready),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  // Credit counts the stage-1 entry as already buffered, so stage 1 can always drain
  // and in_ready depends on registered state only.
  assign occupancy = {1'b0, fifo_count} + (CW + 1)'(s1_valid_q);
  assign in_ready  = occupancy < (CW + 1)'(DEPTH);

  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_mode  = out_valid ? head.mode : SAE_NOP;
  assign out_err   = out_valid && head.err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (s1_valid_q && s1_err_q && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sae_stream.sv
// Directed bench for sae_stream (DATA_W=8, MOD=223, DEPTH=4).
module tb_sae_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_mode;
  logic [7:0] in_data, in_key;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic [1:0] out_mode;
  logic       out_err;
  logic [15:0] err_cnt;

  int total  = 0;
  int passed = 0;
  logic [7:0] got[$];

  localparam logic [1:0] M_NOP = 2'b00, M_KG = 2'b01, M_ENC = 2'b10, M_DEC = 2'b11;

  sae_stream #(.DATA_W(8), .MOD(223), .DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Record any pop happening at the coming edge, then advance to 1ns past it.
  task automatic tick();
    if (out_valid && out_ready) got.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  // Single transaction on an idle pipeline with out_ready high.
  task automatic xact(input string tag, input logic [1:0] mode, input logic [7:0] data,
                      input logic [7:0] key, input logic [7:0] exp_data, input logic exp_err,
                      input logic [15:0] exp_cnt);
    in_valid = 1'b1; in_mode = mode; in_data = data; in_key = key;
    chk({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_k_nov"}, out_valid, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp_data);
    chk({tag, "_err"}, out_err, exp_err);
    chk({tag, "_mode"}, out_mode, mode);
    chk({tag, "_cnt"}, err_cnt, exp_cnt);
    tick();
    chk({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    logic [7:0] bp_data [6];
    logic [7:0] bp_exp  [6];
    int idx;
    logic acc;

    reset = 1'b1; in_valid = 1'b0; in_mode = M_NOP; in_data = '0; in_key = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Known vectors, double reduction, error handling.
    xact("keygen23", M_KG, 8'd0, 8'd23, 8'd200, 1'b0, 16'd0);
    xact("enc100", M_ENC, 8'd100, 8'd200, 8'd77, 1'b0, 16'd0);
    xact("dec77", M_DEC, 8'd77, 8'd23, 8'd100, 1'b0, 16'd0);
    xact("dec255", M_DEC, 8'd255, 8'd222, 8'd31, 1'b0, 16'd0);
    xact("kg_key0", M_KG, 8'd0, 8'd0, 8'd0, 1'b1, 16'd1);
    xact("enc_key223", M_ENC, 8'd5, 8'd223, 8'd0, 1'b1, 16'd2);
    xact("dec_after_err", M_DEC, 8'd77, 8'd23, 8'd100, 1'b0, 16'd2);

    // Backpressure: six ENC offers with the consumer stalled.
    for (int i = 0; i < 6; i++) begin
      bp_data[i] = 8'(200 + 10 * i);
    end
    bp_exp = '{8'd7, 8'd17, 8'd27, 8'd37, 8'd47, 8'd57};
    got.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 6); in_mode = M_ENC; in_data = bp_data[idx % 6]; in_key = 8'd30;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head_valid", out_valid, 1);
    chk("bp_head_stable", out_data, 7);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 6); in_mode = M_ENC; in_data = bp_data[idx % 6]; in_key = 8'd30;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 6);
    chk("bp_out_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) chk($sformatf("bp_out%0d", i), got[i], bp_exp[i]);
    end

    // NOP interleave: a NOP with a bad key neither outputs nor counts an error.
    got.delete();
    in_valid = 1'b1; in_mode = M_ENC; in_data = 8'd10; in_key = 8'd5;
    tick();
    in_mode = M_NOP; in_data = 8'd99; in_key = 8'd0;
    tick();
    in_mode = M_ENC; in_data = 8'd220; in_key = 8'd10;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("nop_out_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("nop_out0", got[0], 15);
      chk("nop_out1", got[1], 7);
    end
    chk("nop_err_cnt", err_cnt, 2);

    // Reset with three entries buffered and stage 1 occupied.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = M_ENC; in_data = 8'd1; in_key = 8'd1;
    for (int c = 0; c < 4; c++) tick();
    in_valid = 1'b0;
    chk("pre_rst_in_ready", in_ready, 0);
    chk("pre_rst_out_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    got.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("post_rst_no_output", got.size(), 0);
    chk("post_rst_out_valid", out_valid, 0);
    xact("post_rst_kg1", M_KG, 8'd0, 8'd1, 8'd222, 1'b0, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
